// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared 8-bit ALU.
// Issue stage (p0) drives the ALU; response stage (p1) captures its result under backpressure.
module alu_arbiter #(
    parameter int NUM_CMDS = 10,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_cmd,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_cmd,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_rslt,
    input  logic              alu_flag,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_rslt,
    output logic              resp_flag,
    output logic              resp_err
);

    function automatic logic is_illegal(input logic [3:0] cmd);
        return int'(cmd) >= NUM_CMDS;
    endfunction

    function automatic logic [DATA_W-1:0] mask_rslt(input logic err, input logic [DATA_W-1:0] r);
        return err ? '0 : r;
    endfunction

    logic              rsp_load, iss_load;
    logic              win0, win1, hs0, hs1;
    logic              last_grant_q, last_grant_d;

    logic              vld_p0_q, vld_p0_d;
    logic              id_p0_q, id_p0_d;
    logic [3:0]        cmd_p0_q, cmd_p0_d;
    logic [DATA_W-1:0] a_p0_q, a_p0_d;
    logic [DATA_W-1:0] b_p0_q, b_p0_d;
    logic              err_p0;

    logic              vld_p1_q, vld_p1_d;
    logic              id_p1_q, id_p1_d;
    logic [DATA_W-1:0] rslt_p1_q, rslt_p1_d;
    logic              flag_p1_q, flag_p1_d;
    logic              err_p1_q, err_p1_d;

    // Arbitration: the loser's payload never reaches the ready path.
    always_comb begin
        rsp_load   = !vld_p1_q || resp_ready;
        iss_load   = !vld_p0_q || rsp_load;
        win0       = req0_valid && (!req1_valid || last_grant_q);
        win1       = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = rst_n && win0 && iss_load;
        req1_ready = rst_n && win1 && iss_load;
        hs0        = req0_valid && req0_ready;
        hs1        = req1_valid && req1_ready;
    end

    // Stage p0: issue register
    always_comb begin
        vld_p0_d     = vld_p0_q;
        id_p0_d      = id_p0_q;
        cmd_p0_d     = cmd_p0_q;
        a_p0_d       = a_p0_q;
        b_p0_d       = b_p0_q;
        last_grant_d = last_grant_q;
        if (iss_load) begin
            vld_p0_d = hs0 || hs1;
            id_p0_d  = hs1;
            cmd_p0_d = hs1 ? req1_cmd : req0_cmd;
            a_p0_d   = hs1 ? req1_a   : req0_a;
            b_p0_d   = hs1 ? req1_b   : req0_b;
        end
        if (hs0) begin
            last_grant_d = 1'b0;
        end else if (hs1) begin
            last_grant_d = 1'b1;
        end
    end

    assign err_p0  = is_illegal(cmd_p0_q);
    assign alu_cmd = vld_p0_q ? cmd_p0_q : 4'd0;
    assign alu_a   = vld_p0_q ? a_p0_q   : '0;
    assign alu_b   = vld_p0_q ? b_p0_q   : '0;

    // Stage p1: response register
    always_comb begin
        vld_p1_d  = vld_p1_q;
        id_p1_d   = id_p1_q;
        rslt_p1_d = rslt_p1_q;
        flag_p1_d = flag_p1_q;
        err_p1_d  = err_p1_q;
        if (rsp_load) begin
            vld_p1_d = vld_p0_q;
            if (vld_p0_q) begin
                id_p1_d   = id_p0_q;
                err_p1_d  = err_p0;
                rslt_p1_d = mask_rslt(err_p0, alu_rslt);
                flag_p1_d = !err_p0 && alu_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            vld_p0_q     <= 1'b0;
            id_p0_q      <= 1'b0;
            vld_p1_q     <= 1'b0;
            id_p1_q      <= 1'b0;
            rslt_p1_q    <= '0;
            flag_p1_q    <= 1'b0;
            err_p1_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_p0_q     <= vld_p0_d;
            id_p0_q      <= id_p0_d;
            vld_p1_q     <= vld_p1_d;
            id_p1_q      <= id_p1_d;
            rslt_p1_q    <= rslt_p1_d;
            flag_p1_q    <= flag_p1_d;
            err_p1_q     <= err_p1_d;
        end
    end

    // Issue payload is only observed while vld_p0_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        cmd_p0_q <= cmd_p0_d;
        a_p0_q   <= a_p0_d;
        b_p0_q   <= b_p0_d;
    end

    assign resp_valid = vld_p1_q;
    assign resp_id    = id_p1_q;
    assign resp_rslt  = rslt_p1_q;
    assign resp_flag  = flag_p1_q;
    assign resp_err   = err_p1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the DUT's ALU port,
// accepted requests push expected responses, a monitor pops and compares them.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                           OP_CMP = 4'd8, OP_SH  = 4'd9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_cmd, req1_cmd, alu_cmd;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_rslt, resp_rslt;
    logic       alu_flag, resp_valid, resp_ready, resp_id, resp_flag, resp_err;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_CMDS(10), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rslt(alu_rslt), .alu_flag(alu_flag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_rslt(resp_rslt), .resp_flag(resp_flag), .resp_err(resp_err)
    );

    // Behavioural ALU: returns {flag, rslt}; illegal codes give garbage that must be masked.
    function automatic logic [8:0] alu_ref(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            OP_SHL:  return {a, 1'b0};
            OP_SHR:  return {a[0], 1'b0, a[7:1]};
            OP_CMP:  return {a == b, 8'h00};
            OP_SH:   return {1'b0, a << b[2:0]};
            default: return {1'b1, a ^ b ^ 8'hA5};
        endcase
    endfunction

    always_comb {alu_flag, alu_rslt} = alu_ref(alu_cmd, alu_a, alu_b);

    typedef struct packed {
        logic       id;
        logic [7:0] rslt;
        logic       flag;
        logic       err;
    } exp_t;

    function automatic exp_t model(input logic id, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [8:0] s;
        s      = alu_ref(c, a, b);
        e.id   = id;
        e.err  = (c >= 4'd10);
        e.rslt = e.err ? 8'h00 : s[7:0];
        e.flag = e.err ? 1'b0 : s[8];
        return e;
    endfunction

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic tb_last = 1'b1;
    logic hs0_seen = 1'b0;
    logic hs1_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Arbitration model and scoreboard push, 3 time units after each rising edge.
    initial begin : arb_checker
        logic w0, w1, full;
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                check("ready0_in_reset", 32'(req0_ready), 32'd0);
                check("ready1_in_reset", 32'(req1_ready), 32'd0);
                sb.delete();
                tb_last  = 1'b1;
                hs0_seen = 1'b0;
                hs1_seen = 1'b0;
            end else begin
                w0   = req0_valid && (!req1_valid || tb_last);
                w1   = req1_valid && (!req0_valid || !tb_last);
                full = (sb.size() == 2) && !resp_ready;
                check("req0_ready", 32'(req0_ready), 32'(w0 && !full));
                check("req1_ready", 32'(req1_ready), 32'(w1 && !full));
                hs0_seen = req0_valid && req0_ready;
                hs1_seen = req1_valid && req1_ready;
                if (hs0_seen) begin
                    sb.push_back(model(1'b0, req0_cmd, req0_a, req0_b));
                    tb_last = 1'b0;
                end
                if (hs1_seen) begin
                    sb.push_back(model(1'b1, req1_cmd, req1_a, req1_b));
                    tb_last = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    check("resp", 32'({resp_id, resp_rslt, resp_flag, resp_err}), 32'(sb[0]));
                    if (resp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_cmd = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_cmd = c; req0_a = a; req0_b = b;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!(id ? hs1_seen : hs0_seen) && n < 20);
        check("send_accept", 32'(id ? hs1_seen : hs0_seen), 32'd1);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic check_resp(input string name, input logic id, input logic [7:0] r, input logic f, input logic e);
        check({name, "_valid"}, 32'(resp_valid), 32'd1);
        check({name, "_fields"}, 32'({resp_id, resp_rslt, resp_flag, resp_err}), 32'({id, r, f, e}));
    endtask

    initial begin : stimulus
        logic prev_id;
        int   n;
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_cmd = OP_ADD; req0_a = 8'h55; req0_b = 8'h66;
        req1_valid = 1'b1; req1_cmd = OP_SUB; req1_a = 8'h77; req1_b = 8'h11;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({resp_valid, resp_id, resp_rslt, resp_flag, resp_err}), 32'd0);
        check("rst_alu", 32'({alu_cmd, alu_a, alu_b}), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Idle: payloads present but no valid, ALU port stays zero
        repeat (3) begin
            step();
            check("idle_alu", 32'({alu_cmd, alu_a, alu_b}), 32'd0);
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
        end

        // Single request and latency
        send(1'b0, OP_ADD, 8'd255, 8'd1);
        check("lat_early", 32'(resp_valid), 32'd0);
        step();
        check_resp("single_add", 1'b0, 8'd0, 1'b1, 1'b0);
        repeat (2) step();

        // Tie: strict alternation, one response per cycle
        req0_valid = 1'b1; req0_cmd = OP_ADD; req0_a = 8'd18; req0_b = 8'd49;
        req1_valid = 1'b1; req1_cmd = OP_CMP; req1_a = 8'd27; req1_b = 8'd27;
        prev_id = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i >= 2) begin
                check("tie_resp_valid", 32'(resp_valid), 32'd1);
                if (i > 2) check("tie_alternate", 32'(resp_id), 32'(!prev_id));
                prev_id = resp_id;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step();

        // Backpressure: AND then OR from req1 while the consumer stalls
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_cmd = OP_AND; req1_a = 8'h2F; req1_b = 8'hB2;
        step();
        check("bp_and_accept", 32'(hs1_seen), 32'd1);
        req1_cmd = OP_OR;
        step();
        check("bp_or_accept", 32'(hs1_seen), 32'd1);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_cmd = OP_ADD; req0_a = 8'd1; req0_b = 8'd2;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_resp("bp_hold", 1'b1, 8'h22, 1'b0, 1'b0);
            check("bp_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        check_resp("bp_or", 1'b1, 8'hBF, 1'b0, 1'b0);
        check("bp_add_accept", 32'(hs0_seen), 32'd1);
        req0_valid = 1'b0;
        step();
        check_resp("bp_add", 1'b0, 8'd3, 1'b0, 1'b0);
        repeat (2) step();

        // Illegal command
        send(1'b0, 4'hF, 8'd7, 8'd9);
        step();
        check_resp("illegal", 1'b0, 8'd0, 1'b0, 1'b1);
        repeat (2) step();

        // Reset while two operations are in flight
        req0_valid = 1'b1; req0_cmd = OP_ADD; req0_a = 8'd5; req0_b = 8'd6;
        req1_valid = 1'b1; req1_cmd = OP_SUB; req1_a = 8'd9; req1_b = 8'd3;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("midrst_resp", 32'({resp_valid, resp_id, resp_rslt, resp_flag, resp_err}), 32'd0);
        check("midrst_alu", 32'({alu_cmd, alu_a, alu_b}), 32'd0);
        check("midrst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            check("postrst_resp_valid", 32'(resp_valid), 32'd0);
            check("postrst_alu", 32'({alu_cmd, alu_a, alu_b}), 32'd0);
        end

        // First tie after reset goes to requester 0
        req0_valid = 1'b1; req0_cmd = OP_XOR; req0_a = 8'h0F; req0_b = 8'hF0;
        req1_valid = 1'b1; req1_cmd = OP_AND; req1_a = 8'hFF; req1_b = 8'h0F;
        step();
        check("first_tie_req0", 32'({hs0_seen, hs1_seen}), 32'b10);
        step();
        check("second_tie_req1", 32'({hs0_seen, hs1_seen}), 32'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step();

        // Randomized traffic with random backpressure and illegal codes
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || hs0_seen) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_cmd   = 4'($urandom_range(0, 15));
                req0_a     = 8'($urandom);
                req0_b     = 8'($urandom);
            end
            if (!req1_valid || hs1_seen) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_cmd   = 4'($urandom_range(0, 15));
                req1_a     = 8'($urandom);
                req1_b     = 8'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        resp_ready = 1'b1;
        n = 0;
        while (n < 50) begin
            if (req0_valid && hs0_seen) req0_valid = 1'b0;
            if (req1_valid && hs1_seen) req1_valid = 1'b0;
            if (!req0_valid && !req1_valid) break;
            step();
            n++;
        end
        check("drain_requests", 32'({req0_valid, req1_valid}), 32'd0);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and issue sequencer for the shared 8-bit combinational `alu`. It accepts operation requests (`cmd`, A, B) from two independent clients over valid/ready handshakes and drives the single ALU instance. It returns each result, flag and requester id on a registered response channel with backpressure. The block sits between the decode/control logic and the ALU, so that two engines (e.g. address-generation and main datapath) can share one ALU without contention.

## Interface
- `NUM_CMDS`, default 10: command codes `>= NUM_CMDS` are illegal. Legal codes are 0000 ADD through 1001 SH.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0's operation is accepted this cycle.
- `req0_cmd`  in  4  ALU command.
- `req0_a`, `req0_b`  in  8  operands A and B.
- `req1_valid`, `req1_ready`, `req1_cmd`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `alu_cmd`  out  4  to `alu.alu_cmd`.
- `alu_a`, `alu_b`  out  8  to `alu.inA` / `alu.inB`.
- `alu_rslt`  in  8  from `alu.rslt`.
- `alu_flag`  in  1  from `alu.out` (carry / equal flag).
- `resp_valid`  out  1  the response register holds a result.
- `resp_ready`  in  1  the consumer takes the response this cycle.
- `resp_id`  out  1  requester that issued the operation.
- `resp_rslt`  out  8  ALU result; forced to 0 when `resp_err` = 1.
- `resp_flag`  out  1  ALU flag; forced to 0 when `resp_err` = 1.
- `resp_err`  out  1  the command was illegal.

## Operation
- Two-stage pipeline:
  - The issue register (ISS) holds valid, id, cmd, a, b and drives the `alu_*` outputs directly.
  - The response register (RSP) captures `alu_rslt`/`alu_flag` plus the id and error bit from ISS.
- `rsp_load = !resp_valid || resp_ready`.
- `iss_load = !iss_valid || rsp_load`.
- Arbitration is combinational from the `reqN_valid` inputs and `last_grant`:
  - Only one requester valid: that requester wins.
  - Both valid: the requester != `last_grant` wins.
  - `reqN_ready = win_N && iss_load`.
  - `reqN_ready` never depends on the loser's `cmd`/`a`/`b`.
- On a handshake (`reqN_valid && reqN_ready`):
  - ISS loads {1, N, cmd, a, b}.
  - `last_grant` <= N.
  - `last_grant` is updated only on an accepted handshake.
- If `iss_load` is high and no handshake occurs, ISS is cleared to invalid.
- If `iss_valid && rsp_load`, RSP loads:
  - `id`
  - `err = (cmd >= NUM_CMDS)`
  - `rslt = err ? 0 : alu_rslt`
  - `flag = err ? 0 : alu_flag`
- If `rsp_load` is high and ISS is invalid, `resp_valid` is cleared.
- Backpressure: if `resp_ready` is low while `resp_valid` is high, RSP holds, ISS holds, and both `reqN_ready` are 0. No data is lost or duplicated.
- When ISS is invalid, the `alu_*` outputs are 0 (`alu_cmd` = 0000, a = 0, b = 0).
- Illegal commands are still driven to the ALU. Their output is discarded and the response is reported with `resp_err` = 1.
- Requesters must hold `valid` and the payload stable until `ready`. The block does not check this.

## Timing
- Reset (async assert, synchronous deassert external to the block):
  - ISS and RSP invalid.
  - `resp_valid` = 0; `resp_id`, `resp_rslt`, `resp_flag`, `resp_err` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - `reqN_ready` = 0 while `rst_n` = 0.
- Latency: handshake at edge E → ALU driven during cycle E..E+1 → response captured at E+1 → `resp_valid` high after E+1.
- Throughput: one operation per cycle while `resp_ready` = 1.
- Stall release: the first edge with `resp_ready` = 1 retires RSP, advances ISS into RSP and may accept a new request, all on the same edge.
- Simultaneous requests: they are served strictly alternately, 0, 1, 0, 1, ...
- A requester that drops `valid` forfeits its turn; `last_grant` is unchanged.
- Reset mid-operation: in-flight ISS and RSP contents are discarded and no response is emitted for them.

## Test plan
- Single request, using the ALU model's semantics: req0 ADD a=255, b=1 with `resp_ready` = 1 → two edges later `resp_valid` = 1, id = 0, rslt = 0, flag = 1, err = 0.
- Tie and fairness: req0 and req1 valid continuously for 6 cycles, with req0 ADD 18+49 and req1 CMP 27,27 → responses alternate id 0, 1, 0, 1, 0, 1.
  - Each req0 response is rslt = 67, flag = 0.
  - Each req1 response is rslt = 0, flag = 1.
  - One response per cycle after the first two cycles.
- Backpressure: req1 AND 0x2F,0xB2 and then OR, with `resp_ready` = 0 for 3 cycles.
  - `resp_valid` holds rslt = 0x22 and both readies stay 0.
  - On release: AND is retired, the OR response follows the next cycle, and there are no drops or duplicates.
- Illegal command: req0 cmd = 4'b1111, a = 7, b = 9 → response err = 1, rslt = 0, flag = 0, id = 0.
- Reset mid-flight: issue two requests, then pull `rst_n` low between the accept and the response → all outputs go to 0 immediately and no response appears after reset.
- Idle defaults: no requests → `alu_cmd` = 0, `alu_a` = `alu_b` = 0, `resp_valid` stays 0, and the first tie after reset grants req0.
